// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder: boot-programmable 68000 chip-select table with per-region
// wait states, external ready gating and a bus-error timeout on unmapped accesses.
module m68k_region_decoder #(
  parameter  int REGIONS      = 16,
  parameter  int ADDR_W       = 24,
  parameter  int WAIT_W       = 4,
  parameter  int BERR_TIMEOUT = 255,
  localparam int IDX_W        = $clog2(REGIONS),
  localparam int TCNT_W       = $clog2(BERR_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W-1:0]  cfg_mask,
  input  logic [WAIT_W-1:0]  cfg_wait,
  input  logic [1:0]         cfg_dir,
  input  logic [ADDR_W-1:0]  m68k_a,
  input  logic               m68k_as_n,
  input  logic               m68k_rw,
  input  logic               ext_ready,
  output logic [REGIONS-1:0] cs,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               dtack_n,
  output logic               berr_n,
  output logic               busy
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_NOMAP, S_BERR} state_t;
  logic               r_en   [REGIONS];
  logic [ADDR_W-1:0]  r_base [REGIONS];
  logic [ADDR_W-1:0]  r_mask [REGIONS];
  logic [WAIT_W-1:0]  r_wait [REGIONS];
  logic [1:0]         r_dir  [REGIONS];
  state_t             r_state;
  logic [WAIT_W-1:0]  r_cnt;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [REGIONS-1:0] r_cs;
  logic [IDX_W-1:0]   r_hit_idx;
  logic               r_dtack_n;
  logic               r_berr_n;
  logic               r_busy;
  logic [REGIONS-1:0] w_match;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hit;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < REGIONS; i++) begin
        r_en[i]   <= 1'b0;
        r_base[i] <= '0;
        r_mask[i] <= '0;
        r_wait[i] <= '0;
        r_dir[i]  <= '0;
      end
    end else if (cfg_we) begin
      r_en[cfg_idx]   <= cfg_en;
      r_base[cfg_idx] <= cfg_base;
      r_mask[cfg_idx] <= cfg_mask;
      r_wait[cfg_idx] <= cfg_wait;
      r_dir[cfg_idx]  <= cfg_dir;
    end
  always_comb
    for (int i = 0; i < REGIONS; i++)
      w_match[i] = r_en[i] && ((m68k_a ^ r_base[i]) & r_mask[i]) == '0 &&
                   (r_dir[i] == 2'd0 || (r_dir[i] == 2'd1 && m68k_rw) || (r_dir[i] == 2'd2 && !m68k_rw));
  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_idx = '0;
    for (int i = REGIONS - 1; i >= 0; i--)
      if (w_match[i]) w_idx = IDX_W'(i);
  end
  assign w_hit = |w_match;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_cs      <= '0;
      r_hit_idx <= '0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (!m68k_as_n) begin
            r_busy <= 1'b1;
            if (w_hit) begin
              r_state   <= S_WAIT;
              r_cs      <= REGIONS'(1) << w_idx;
              r_hit_idx <= w_idx;
              r_cnt     <= r_wait[w_idx];
            end else begin
              r_state <= S_NOMAP;
              r_tcnt  <= TCNT_W'(BERR_TIMEOUT - 1);
            end
          end
        S_WAIT:
          if (m68k_as_n) begin
            r_state <= S_IDLE;
            r_cs    <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) r_cnt <= r_cnt - WAIT_W'(1);
          else if (ext_ready) begin
            r_state   <= S_ACK;
            r_dtack_n <= 1'b0;
          end
        S_ACK:
          if (m68k_as_n) begin
            r_state   <= S_IDLE;
            r_cs      <= '0;
            r_dtack_n <= 1'b1;
            r_busy    <= 1'b0;
          end
        S_NOMAP:
          if (m68k_as_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tcnt != '0) r_tcnt <= r_tcnt - TCNT_W'(1);
          else begin
            r_state  <= S_BERR;
            r_berr_n <= 1'b0;
          end
        S_BERR:
          if (m68k_as_n) begin
            r_state  <= S_IDLE;
            r_berr_n <= 1'b1;
            r_busy   <= 1'b0;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  assign cs      = r_cs;
  assign hit_idx = r_hit_idx;
  assign dtack_n = r_dtack_n;
  assign berr_n  = r_berr_n;
  assign busy    = r_busy;
endmodule

// File: tb/tb_m68k_region_decoder.sv
// tb_m68k_region_decoder: directed and randomized bus cycles checked against a
// table-lookup reference model of the region decoder.
module tb_m68k_region_decoder;
  localparam int REGIONS = 16;
  localparam int ADDR_W  = 24;
  localparam int WAIT_W  = 4;
  localparam int BT      = 8;
  localparam int IW      = 4;
  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [IW-1:0]      cfg_idx = '0;
  logic               cfg_en = 1'b0;
  logic [ADDR_W-1:0]  cfg_base = '0;
  logic [ADDR_W-1:0]  cfg_mask = '0;
  logic [WAIT_W-1:0]  cfg_wait = '0;
  logic [1:0]         cfg_dir = '0;
  logic [ADDR_W-1:0]  m68k_a = '0;
  logic               m68k_as_n = 1'b1;
  logic               m68k_rw = 1'b1;
  logic               ext_ready = 1'b1;
  logic [REGIONS-1:0] cs;
  logic [IW-1:0]      hit_idx;
  logic               dtack_n;
  logic               berr_n;
  logic               busy;
  int vectors = 0;
  int miscompares = 0;
  bit          m_en   [REGIONS];
  logic [23:0] m_base [REGIONS];
  logic [23:0] m_mask [REGIONS];
  int          m_wait [REGIONS];
  int          m_dir  [REGIONS];
  int          m_last = 0;

  m68k_region_decoder #(.REGIONS(REGIONS), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .BERR_TIMEOUT(BT)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_wait(cfg_wait), .cfg_dir(cfg_dir),
    .m68k_a(m68k_a), .m68k_as_n(m68k_as_n), .m68k_rw(m68k_rw), .ext_ready(ext_ready),
    .cs(cs), .hit_idx(hit_idx), .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear;
    for (int i = 0; i < REGIONS; i++) begin
      m_en[i] = 0; m_base[i] = '0; m_mask[i] = '0; m_wait[i] = 0; m_dir[i] = 0;
    end
  endfunction

  // Lowest entry whose masked address agrees and whose direction permits the access.
  function automatic int lookup(input logic [23:0] a, input logic rw);
    bit allowed;
    for (int i = 0; i < REGIONS; i++) begin
      allowed = (m_dir[i] == 0) ? 1'b1 : (m_dir[i] == 1) ? rw : (m_dir[i] == 2) ? !rw : 1'b0;
      if (m_en[i] && allowed && (a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    end
    return -1;
  endfunction

  task automatic cfg_write(input int idx, input bit en, input logic [23:0] base,
                           input logic [23:0] mask, input int w, input int d);
    cfg_idx = IW'(idx); cfg_en = en; cfg_base = base; cfg_mask = mask;
    cfg_wait = WAIT_W'(w); cfg_dir = 2'(d); cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
    m_en[idx] = en; m_base[idx] = base; m_mask[idx] = mask; m_wait[idx] = w; m_dir[idx] = d;
  endtask

  task automatic release_check(input string tag);
    m68k_as_n = 1'b1; ext_ready = 1'b1;
    tick;
    chk({tag, ":release"}, {13'h0, cs, dtack_n, berr_n, busy}, {13'h0, 16'h0, 1'b1, 1'b1, 1'b0});
    chk({tag, ":hit_idx_kept"}, 32'(hit_idx), m_last);
  endtask

  // One full bus cycle; ext_ready is sampled low on the first nlow edges after E0.
  task automatic run_cycle(input string tag, input logic [23:0] a, input logic rw, input int nlow);
    int idx, exp_k, k;
    idx = lookup(a, rw);
    exp_k = (idx < 0) ? BT : ((1 + m_wait[idx]) > (nlow + 1) ? 1 + m_wait[idx] : nlow + 1);
    m68k_a = a; m68k_rw = rw; ext_ready = (nlow == 0); m68k_as_n = 1'b0;
    tick;
    if (idx >= 0) m_last = idx;
    chk({tag, ":busy"}, 32'(busy), 1);
    chk({tag, ":cs"}, 32'(cs), idx < 0 ? 32'h0 : 32'(1) << idx);
    chk({tag, ":hit_idx"}, 32'(hit_idx), m_last);
    k = 0;
    do begin
      tick;
      k++;
      if (k >= nlow) ext_ready = 1'b1;
    end while (dtack_n && berr_n && k < 64);
    chk({tag, ":resp_edge"}, k, exp_k);
    chk({tag, ":resp_kind"}, {30'h0, dtack_n, berr_n}, idx < 0 ? 32'h2 : 32'h1);
    release_check(tag);
  endtask

  initial begin
    int k;
    logic [23:0] msk, a;
    int j;
    model_clear();
    tick; tick;
    chk("reset", {11'h0, cs, hit_idx, dtack_n, berr_n, busy}, {11'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b0});
    reset_n = 1'b1;
    tick;
    cfg_write(2, 1, 24'h100000, 24'hFFF000, 0, 0);
    run_cycle("idx2_read", 24'h100A42, 1'b1, 0);
    cfg_write(1, 1, 24'h040000, 24'hFFFF00, 3, 0);
    cfg_write(5, 1, 24'h040010, 24'hFFFFFF, 0, 0);
    run_cycle("overlap", 24'h040010, 1'b1, 0);
    cfg_write(0, 1, 24'h000000, 24'hFC0000, 0, 1);
    run_cycle("ro_write_berr", 24'h000100, 1'b0, 0);
    run_cycle("ro_read", 24'h000100, 1'b1, 0);
    run_cycle("ready_low5", 24'h100A42, 1'b1, 5);
    // abort in WAIT with cnt=2
    m68k_a = 24'h040010; m68k_rw = 1'b1; m68k_as_n = 1'b0;
    tick;
    tick;
    chk("abort:dtack_high", 32'(dtack_n), 1);
    m68k_as_n = 1'b1;
    tick;
    m_last = 1;
    chk("abort:release", {14'h0, cs, dtack_n, busy}, {14'h0, 16'h0, 1'b1, 1'b0});
    tick;
    chk("abort:dtack_stays", 32'(dtack_n), 1);
    // retarget idx1 while its cycle waits: old wait of 3 still applies
    m68k_as_n = 1'b0;
    tick;
    tick;
    cfg_write(1, 1, 24'h040000, 24'hFFFF00, 0, 0);
    k = 2;
    do begin
      tick;
      k++;
    end while (dtack_n && k < 64);
    chk("retarget:old_wait", k, 4);
    chk("retarget:cs", 32'(cs), 32'h2);
    release_check("retarget");
    run_cycle("retarget_next", 24'h040010, 1'b1, 0);
    // reset pulse while in ACK
    m68k_a = 24'h100A42; m68k_as_n = 1'b0;
    tick;
    tick;
    chk("ack_before_reset", 32'(dtack_n), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", {11'h0, cs, hit_idx, dtack_n, berr_n, busy}, {11'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b0});
    m68k_as_n = 1'b1;
    tick;
    reset_n = 1'b1;
    model_clear();
    m_last = 0;
    tick;
    run_cycle("table_cleared", 24'h100A42, 1'b1, 0);
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < 2; w++) begin
        msk = 24'hFFFFFF << $urandom_range(8, 22);
        cfg_write($urandom_range(0, REGIONS - 1), $urandom_range(0, 3) != 0, 24'($urandom),
                  msk, $urandom_range(0, 15), $urandom_range(0, 3));
      end
      for (int c = 0; c < 3; c++) begin
        j = $urandom_range(0, REGIONS - 1);
        a = ($urandom_range(0, 3) == 0) ? 24'($urandom)
                                         : (m_base[j] & m_mask[j]) | (24'($urandom) & ~m_mask[j]);
        run_cycle("random", a, 1'($urandom), $urandom_range(0, 6));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
